exp_requester: RTL and testbench
================================

# exp_requester

Initiator side of the exponential unit's start/done handshake. Accepts operands on a valid/ready stream and buffers them in a small FIFO. Sequences each operand through the unit, holding x stable while start is high, and captures {intpart,fracpart} into a valid/ready result register. It sits between the operand source (bus or host logic) and one exponential instance, so upstream logic never has to track the unit's multi-cycle protocol.

## Interface
- DEPTH, 4: operand FIFO entries, power of two, ≥2
- START_CYCLES, 2: cycles exp_start is held high per launch, ≥1
- TIMEOUT, 256: max cycles in WAIT_DONE (used only with the watchdog macro)
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  operand offered
- in_ready  out  1  FIFO not full
- in_x  in  16  operand (unsigned fraction, same format as the unit's x)
- exp_start  out  1  to unit start
- exp_x  out  16  to unit x; registered
- exp_done  in  1  from unit done (high whenever the unit is idle)
- exp_int  in  2  from unit intpart
- exp_frac  in  16  from unit fracpart
- out_valid  out  1  result held
- out_ready  in  1  result consumer ready
- out_data  out  18  {int,frac} captured result
- busy  out  1  state ≠ IDLE or FIFO not empty
- err_timeout  out  1  sticky watchdog flag (0 when macro absent)

## Operation
- FSM states: IDLE, LAUNCH, WAIT_DONE, HOLD.
- IDLE:
  - if FIFO not empty and exp_done=1: pop head into exp_x, load launch counter with START_CYCLES-1, clear seen_low, go LAUNCH.
  - if exp_done=0 (unit busy from elsewhere or after reset): stay.
- LAUNCH:
  - exp_start=1 and exp_x stable.
  - each cycle with exp_done=0 sets seen_low.
  - when the counter reaches 0, go WAIT_DONE. exp_start falls on that transition.
- WAIT_DONE:
  - exp_start=0; exp_done=0 sets seen_low.
  - when exp_done=1 and seen_low=1: capture out_data={exp_int,exp_frac}, set out_valid, go HOLD.
  - a done=1 sample before seen_low is set is ignored, because done stays high until the unit leaves Idle.
- HOLD: out_valid=1, out_data stable. On out_valid&out_ready, clear out_valid and go IDLE. Launches are strictly serial.
- FIFO:
  - push on in_valid&in_ready.
  - pop only in the IDLE→LAUNCH transition.
  - simultaneous push and pop when full is not allowed: in_ready is !full, not pop-aware.
  - pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. The extra MSB distinguishes full from empty.
- Reset (including mid-operation):
  - FIFO empty; state IDLE.
  - exp_start=0, exp_x=0, out_valid=0, out_data=0, busy=0, err_timeout=0, in_ready=1.
  - the unit shares rst, so both sides reset together.

## Timing
- exp_start rises the cycle after the IDLE pop edge and stays high exactly START_CYCLES cycles.
- done is expected low one cycle after start rises. seen_low is normally set within LAUNCH.
- Result capture happens on the first rising clock edge with exp_done=1 after seen_low. out_valid is high the following cycle.
- Minimum throughput: one result per START_CYCLES + unit latency + 2 cycles, plus the HOLD cycles spent waiting for out_ready.
- in_ready is combinational from FIFO count only. A push is visible to IDLE on the next cycle.

## Configuration
- EXP_REQ_TIMEOUT_EN defined:
  - a counter runs in WAIT_DONE.
  - reaching TIMEOUT sets err_timeout (sticky until rst).
  - it also forces HOLD with out_data=18'h3FFFF so the stream never stalls.
- Macro undefined: no counter, err_timeout tied 0, WAIT_DONE waits indefinitely.

## Structure
- Package exp_req_pkg: state enum (IDLE, LAUNCH, WAIT_DONE, HOLD), XW=16, RW=18, timeout sentinel constant.
- One sub-module: exp_op_fifo (synchronous FIFO with DEPTH/width parameters, push/pop/full/empty/head).
- The top holds the FSM, launch counter, seen_low, result register and watchdog.

## Test plan
All scenarios use a behavioural unit model with 7-cycle latency unless noted.
- Single op: push x=16'h0000; model returns int=1, frac=0. Expect exp_start high 2 cycles, then out_data=18'h10000; out_valid held until out_ready.
- Back-to-back: push 16'h4000, 16'h8000, 16'hFFFF with out_ready=1. Expect 3 results in order and 3 separate start pulses. exp_x must not change while exp_start=1.
- Full FIFO: push 5 with no pops possible (model done=0 held). in_ready=0 after the 4th; the 5th is not accepted; later, all 4 drain in order.
- Stale done: after reset, model holds done=1. Expect no capture until done has gone low, and out_valid never asserts before the unit's busy period.
- Reset mid-op: assert rst during WAIT_DONE. Expect exp_start=0, out_valid=0, busy=0 immediately, and the FIFO empty.
- Watchdog (macro defined, TIMEOUT=16): model never raises done. Expect err_timeout=1 and out_data=18'h3FFFF after 16 cycles in WAIT_DONE.

Source files
------------

// File: rtl/exp_req_pkg.sv
// Shared types and constants for the exponential-unit requester.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package exp_req_pkg;

   localparam int XW = 16;                   // operand width (unit x)
   localparam int RW = 18;                   // result width {intpart, fracpart}

   // Result substituted when the unit never answers, so the stream keeps moving
   localparam logic [RW-1:0] TIMEOUT_DATA = 18'h3FFFF;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT_DONE,
      HOLD
   } state_t;

endpackage

// File: rtl/exp_op_fifo.sv
// Operand FIFO: synchronous, power-of-two depth, head visible combinationally.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: full blocks further pushes; pop on empty and push on full are ignored.
module exp_op_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   // Extra pointer MSB separates the full case from the empty case
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // Pointer update; natural wrap of the AW+1 bit counters is modulo 2*DEPTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty)
            rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage write; contents need no reset because empty masks them
   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/exp_requester.sv
// Initiator for the exponential unit's start/done handshake with operand FIFO and result register.
// Latency: START_CYCLES + unit latency + 2 cycles from FIFO head to out_valid; launches are serial.
// Backpressure: in_ready = FIFO not full; result held in HOLD until out_ready. Watchdog: EXP_REQ_TIMEOUT_EN.
module exp_requester
   import exp_req_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int START_CYCLES = 2,
   parameter int TIMEOUT      = 256
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [XW-1:0] in_x,
   output logic          exp_start,
   output logic [XW-1:0] exp_x,
   input  logic          exp_done,
   input  logic [1:0]    exp_int,
   input  logic [15:0]   exp_frac,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [RW-1:0] out_data,
   output logic          busy,
   output logic          err_timeout
);

   localparam int CW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_ONE = 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || START_CYCLES < 1 || TIMEOUT < 1) begin : g_bad_params
      $error("exp_requester: illegal parameter set");
   end

   state_t        state;
   logic [CW-1:0] launch_cnt;
   logic          seen_low;
   logic          fifo_full;
   logic          fifo_empty;
   logic [XW-1:0] fifo_head;
   logic          pop;
   logic          capture;
   logic          wd_fire;

   // Launch only when the unit reports idle; done is high whenever it is idle
   assign pop      = (state == IDLE) && !fifo_empty && exp_done;
   assign in_ready = !fifo_full;
   assign busy     = (state != IDLE) || !fifo_empty;
   // A done sample counts only after the unit has been seen busy for this launch
   assign capture  = (state == WAIT_DONE) && exp_done && seen_low;

   exp_op_fifo #(
      .DEPTH (DEPTH),
      .W     (XW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (in_valid && in_ready),
      .pop   (pop),
      .din   (in_x),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

`ifdef EXP_REQ_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [WW-1:0] WD_ONE  = 1;
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

   logic [WW-1:0] wd_cnt;

   assign wd_fire = (state == WAIT_DONE) && !capture && (wd_cnt == WD_LAST);

   // Watchdog: counts cycles spent in WAIT_DONE, restarts on every other state
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wd_cnt <= '0;
      else if (state != WAIT_DONE)
         wd_cnt <= '0;
      else if (!wd_fire)
         wd_cnt <= wd_cnt + WD_ONE;
   end

   // Sticky timeout flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_timeout <= 1'b0;
      else if (wd_fire)
         err_timeout <= 1'b1;
   end
`else
   assign wd_fire     = 1'b0;
   assign err_timeout = 1'b0;
`endif

   // Request sequencer: pop, hold start for START_CYCLES, wait for a genuine done, hold result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         launch_cnt <= '0;
         seen_low   <= 1'b0;
         exp_start  <= 1'b0;
         exp_x      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  exp_x      <= fifo_head;
                  launch_cnt <= CW'(START_CYCLES - 1);
                  seen_low   <= 1'b0;
                  exp_start  <= 1'b1;
                  state      <= LAUNCH;
               end
            end
            LAUNCH: begin
               if (!exp_done)
                  seen_low <= 1'b1;
               if (launch_cnt == '0) begin
                  exp_start <= 1'b0;
                  state     <= WAIT_DONE;
               end else begin
                  launch_cnt <= launch_cnt - CNT_ONE;
               end
            end
            WAIT_DONE: begin
               if (capture) begin
                  out_data  <= {exp_int, exp_frac};
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else if (wd_fire) begin
                  out_data  <= TIMEOUT_DATA;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else if (!exp_done) begin
                  seen_low <= 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exp_requester.sv
// Self-checking bench: behavioural exponential unit, result scoreboard, directed and random traffic.
// Latency: unit model answers 7 cycles after going busy (optional extra delay before going busy).
// Backpressure: out_ready driven low, high or random per phase.
module tb_exp_requester;

   localparam int DEPTH = 4;
   localparam int SC    = 2;
   localparam int LAT   = 7;
`ifdef EXP_REQ_TIMEOUT_EN
   localparam int TO    = 16;
`else
   localparam int TO    = 256;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_x = '0;
   logic        exp_start;
   logic [15:0] exp_x;
   logic        exp_done;
   logic [1:0]  exp_int = '0;
   logic [15:0] exp_frac = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [17:0] out_data;
   logic        busy;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exp_requester #(
      .DEPTH        (DEPTH),
      .START_CYCLES (SC),
      .TIMEOUT      (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_x        (in_x),
      .exp_start   (exp_start),
      .exp_x       (exp_x),
      .exp_done    (exp_done),
      .exp_int     (exp_int),
      .exp_frac    (exp_frac),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // e^x for x in [0,1) as a 2.16 fixed-point value
   function automatic logic [17:0] ref_exp(input logic [15:0] x);
      real r;
      r = $exp(real'(x) / 65536.0) * 65536.0;
      return 18'($rtoi(r));
   endfunction

   // ---------------- behavioural exponential unit ----------------
   int          mstate    = 0;      // 0 idle, 1 start seen but not yet busy, 2 busy
   int          mcnt      = 0;
   logic        unit_done = 1'b1;
   bit          hold_busy = 1'b0;   // forces done low from outside (unit used elsewhere)
   bit          never_done = 1'b0;
   int          low_delay = 0;
   logic [15:0] mx;
   bit          was_busy  = 1'b0;

   assign exp_done = unit_done && !hold_busy;

   always @(negedge clk) begin
      if (rst) begin
         mstate    = 0;
         unit_done = 1'b1;
      end else begin
         case (mstate)
            0: if (exp_start) begin
               mx       = exp_x;
               was_busy = 1'b0;
               if (low_delay == 0) begin
                  unit_done = 1'b0;
                  was_busy  = 1'b1;
                  mcnt      = LAT - 1;
                  mstate    = 2;
               end else begin
                  mcnt   = low_delay - 1;
                  mstate = 1;
               end
            end
            1: if (mcnt == 0) begin
               unit_done = 1'b0;
               was_busy  = 1'b1;
               mcnt      = LAT - 1;
               mstate    = 2;
            end else mcnt--;
            default: if (mcnt == 0) begin
               if (!never_done) begin
                  unit_done = 1'b1;
                  {exp_int, exp_frac} = ref_exp(mx);
                  mstate = 0;
               end
            end else mcnt--;
         endcase
      end
   end

   // ---------------- scoreboard and protocol monitor ----------------
   logic [17:0] exp_q[$];
   int          ready_mode = 0;     // 0 low, 1 high, 2 random
   int          start_hi = 0;
   int          start_cnt = 0;
   int          res_cnt = 0;
   logic [15:0] launch_x;
   bit          pend_hold = 1'b0;
   logic [17:0] hold_data;
   logic        prev_valid = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         start_hi   = 0;
         pend_hold  = 1'b0;
         prev_valid = 1'b0;
         out_ready  = 1'b0;
      end else begin
         if (exp_start) begin
            if (start_hi == 0) begin
               launch_x = exp_x;
               start_cnt++;
            end else begin
               check("x_stable", exp_x, launch_x);
            end
            start_hi++;
         end else if (start_hi != 0) begin
            check("start_len", start_hi, SC);
            start_hi = 0;
         end
         if (pend_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_data);
         end
         if (out_valid && !prev_valid)
            check("no_early_valid", was_busy, 1);
         prev_valid = out_valid;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         pend_hold = 1'b0;
         if (out_valid) begin
            if (out_ready) begin
               res_cnt++;
               if (exp_q.size() == 0) check("sb_empty", exp_q.size(), 1);
               else check("result", out_data, exp_q.pop_front());
            end else begin
               pend_hold = 1'b1;
               hold_data = out_data;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic push_op(input logic [15:0] x, output bit acc);
      @(negedge clk);
      in_valid = 1'b1;
      in_x     = x;
      acc      = in_ready;
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (acc) exp_q.push_back(ref_exp(x));
   endtask

   task automatic push_retry(input logic [15:0] x);
      bit acc = 1'b0;
      int n = 0;
      while (!acc && n < 300) begin
         push_op(x, acc);
         n++;
      end
      if (!acc) check("push_retry", acc, 1);
   endtask

   task automatic wait_start(input logic lvl, input string tag);
      int n = 0;
      while (exp_start !== lvl && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (exp_start !== lvl) check(tag, exp_start, lvl);
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((exp_q.size() != 0 || busy || out_valid) && n < 5000);
      check(tag, exp_q.size(), 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      bit acc;
      int n, s0, r0;

      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_start", exp_start, 0);
      check("rst_x", exp_x, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_timeout, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      #2 rst = 1'b0;

      // single operand, consumer stalled for a while
      ready_mode = 0;
      push_op(16'h0000, acc);
      check("single_acc", acc, 1);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("single_valid", out_valid, 1);
      check("single_data", out_data, 18'h10000);
      repeat (3) begin
         @(negedge clk);
         check("single_hold", out_valid, 1);
      end
      ready_mode = 1;
      wait_drain("single_drain");

      // back-to-back operands
      s0 = start_cnt;
      r0 = res_cnt;
      push_retry(16'h4000);
      push_retry(16'h8000);
      push_retry(16'hFFFF);
      wait_drain("b2b_drain");
      check("b2b_starts", start_cnt - s0, 3);
      check("b2b_results", res_cnt - r0, 3);

      // full FIFO while the unit is held busy elsewhere
      hold_busy = 1'b1;
      s0 = start_cnt;
      r0 = res_cnt;
      for (int i = 0; i < DEPTH + 1; i++) begin
         push_op(16'h1000 * 16'(i + 1), acc);
         check("full_accept", acc, 32'(i < DEPTH));
      end
      check("full_in_ready", in_ready, 0);
      check("full_busy", busy, 1);
      repeat (5) @(negedge clk);
      check("full_no_launch", start_cnt - s0, 0);
      hold_busy = 1'b0;
      wait_drain("full_drain");
      check("full_results", res_cnt - r0, DEPTH);

      // stale done: unit stays high for a while after start, outputs hold garbage
      exp_int   = 2'd3;
      exp_frac  = 16'hDEAD;
      low_delay = 3;
      r0 = res_cnt;
      push_retry(16'h2345);
      wait_drain("stale_drain");
      check("stale_results", res_cnt - r0, 1);
      low_delay = 0;

      // reset in WAIT_DONE with a second operand still queued
      ready_mode = 0;
      push_retry(16'h1111);
      push_retry(16'h2222);
      wait_start(1'b1, "mid_start_rise");
      wait_start(1'b0, "mid_start_fall");
      @(negedge clk);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      check("mid_rst_start", exp_start, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_x", exp_x, 0);
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      s0 = start_cnt;
      repeat (20) @(negedge clk);
      check("mid_no_launch", start_cnt - s0, 0);
      check("mid_busy", busy, 0);
      ready_mode = 1;

      // randomized traffic with random consumer stalls and unit response skew
      ready_mode = 2;
      r0 = res_cnt;
      for (int i = 0; i < 40; i++) begin
         low_delay = $urandom_range(0, 2);
         push_retry(16'($urandom));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_drain("rand_drain");
      check("rand_results", res_cnt - r0, 40);
      low_delay  = 0;
      ready_mode = 1;

`ifdef EXP_REQ_TIMEOUT_EN
      // watchdog: unit never signals completion
      ready_mode = 0;
      never_done = 1'b1;
      push_op(16'h0123, acc);
      check("wd_acc", acc, 1);
      void'(exp_q.pop_back());
      exp_q.push_back(18'h3FFFF);
      wait_start(1'b1, "wd_start_rise");
      wait_start(1'b0, "wd_start_fall");
      check("wd_err_before", err_timeout, 0);
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wd_cycles", n, TO);
      check("wd_err", err_timeout, 1);
      check("wd_data", out_data, 18'h3FFFF);
      ready_mode = 1;
      never_done = 1'b0;
      wait_drain("wd_drain");
      check("wd_sticky", err_timeout, 1);
      do_reset();
      #1 check("wd_err_cleared", err_timeout, 0);
`else
      check("err_tied", err_timeout, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
